// File: rtl/vga_fb_pkg.sv
// Shared constants, types and the frame-buffer address helper for the VGA
// frame-buffer arbiter.
//   Timing defaults : 640x480 visible inside an 800x525 raster.
//   Frame buffer    : 160x120 bytes (RGB332), shown with 4x4 replication.
//   Types           : slot_e names the owner of the RAM port this cycle;
//                     mem_req_t bundles one single-port RAM request.
package vga_fb_pkg;

    localparam int unsigned H_ACTIVE_DFLT = 640;
    localparam int unsigned H_TOTAL_DFLT  = 800;
    localparam int unsigned V_ACTIVE_DFLT = 480;
    localparam int unsigned V_TOTAL_DFLT  = 525;

    localparam int unsigned FB_WIDTH   = 160;
    localparam int unsigned FB_HEIGHT  = 120;
    localparam int unsigned FB_SIZE    = FB_WIDTH * FB_HEIGHT;
    localparam int unsigned FB_ADDR_W  = 15;
    localparam int unsigned SCALE_LOG2 = 2;
    localparam int unsigned PIX_W      = 8;

    // Owner of the shared RAM port in the current cycle.
    typedef enum logic {
        SLOT_WRITE = 1'b0,
        SLOT_READ  = 1'b1
    } slot_e;

    // One single-port RAM request.
    typedef struct packed {
        logic                 we;
        logic [FB_ADDR_W-1:0] addr;
        logic [PIX_W-1:0]     data;
    } mem_req_t;

    // Scan position -> frame-buffer address; row*160 built as row*128 + row*32.
    function automatic logic [FB_ADDR_W-1:0] fb_addr(
        input logic [FB_ADDR_W-1:0] h,
        input logic [FB_ADDR_W-1:0] v
    );
        logic [FB_ADDR_W-1:0] row;
        row = v >> SCALE_LOG2;
        return (row << 7) + (row << 5) + (h >> SCALE_LOG2);
    endfunction

endpackage

// File: rtl/vga_scan_counter.sv
// Raster position counter.
//   i_CLK, i_RESET : pixel clock, asynchronous active-high reset
//   o_H_CNT        : column 0..H_TOTAL-1, advances every cycle
//   o_V_CNT        : line 0..V_TOTAL-1, advances on column wrap
//   o_VISIBLE      : current position lies inside the active area
module vga_scan_counter
    import vga_fb_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DFLT,
    parameter int unsigned H_TOTAL  = H_TOTAL_DFLT,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DFLT,
    parameter int unsigned V_TOTAL  = V_TOTAL_DFLT,
    parameter int unsigned H_W      = $clog2(H_TOTAL),
    parameter int unsigned V_W      = $clog2(V_TOTAL)
) (
    input  logic           i_CLK,
    input  logic           i_RESET,
    output logic [H_W-1:0] o_H_CNT,
    output logic [V_W-1:0] o_V_CNT,
    output logic           o_VISIBLE
);

    logic [H_W-1:0] r_h_cnt;
    logic [V_W-1:0] r_v_cnt;

    // Column/line counters with wrap.
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_W'(H_TOTAL - 1)) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_W'(V_TOTAL - 1)) ? '0 : r_v_cnt + V_W'(1);
        end else begin
            r_h_cnt <= r_h_cnt + H_W'(1);
        end
    end

    assign o_H_CNT   = r_h_cnt;
    assign o_V_CNT   = r_v_cnt;
    assign o_VISIBLE = (r_h_cnt < H_W'(H_ACTIVE)) & (r_v_cnt < V_W'(V_ACTIVE));

endmodule

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: shares one single-port RAM between the VGA scan-out
// and game-logic writes. Every fourth visible column is a read slot; every
// other cycle is a write slot.
//   i_CLK, i_RESET            : pixel clock, asynchronous active-high reset
//   i_WR_REQ/ADDR/DATA        : write request (held until o_WR_ACK)
//   o_WR_ACK                  : write taken this cycle (combinational)
//   o_MEM_ADDR/WE/WDATA       : RAM port (combinational)
//   i_MEM_RDATA               : RAM data, one cycle after address
//   o_RGB, o_DE               : registered pixel and display enable
//   o_FRAME_START             : combinational pulse at scan position (0,0)
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DFLT,
    parameter int unsigned H_TOTAL  = H_TOTAL_DFLT,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DFLT,
    parameter int unsigned V_TOTAL  = V_TOTAL_DFLT
) (
    input  logic                 i_CLK,
    input  logic                 i_RESET,
    input  logic                 i_WR_REQ,
    input  logic [FB_ADDR_W-1:0] i_WR_ADDR,
    input  logic [PIX_W-1:0]     i_WR_DATA,
    output logic                 o_WR_ACK,
    output logic [FB_ADDR_W-1:0] o_MEM_ADDR,
    output logic                 o_MEM_WE,
    output logic [PIX_W-1:0]     o_MEM_WDATA,
    input  logic [PIX_W-1:0]     i_MEM_RDATA,
    output logic [PIX_W-1:0]     o_RGB,
    output logic                 o_DE,
    output logic                 o_FRAME_START
);

    localparam int unsigned H_W = $clog2(H_TOTAL);
    localparam int unsigned V_W = $clog2(V_TOTAL);

    logic [H_W-1:0]       w_h_cnt;
    logic [V_W-1:0]       w_v_cnt;
    logic                 w_visible;
    logic                 w_read_slot;
    logic                 w_addr_ok;
    logic [FB_ADDR_W-1:0] w_fb_addr;
    slot_e                w_slot;
    mem_req_t             w_mem;

    logic                 r_vis_d1;
    logic                 r_rd_d1;
    logic                 r_de;
    logic [PIX_W-1:0]     r_pix;
    logic [PIX_W-1:0]     r_rgb;

    vga_scan_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_TOTAL  (H_TOTAL),
        .V_ACTIVE (V_ACTIVE),
        .V_TOTAL  (V_TOTAL),
        .H_W      (H_W),
        .V_W      (V_W)
    ) u_scan (
        .i_CLK     (i_CLK),
        .i_RESET   (i_RESET),
        .o_H_CNT   (w_h_cnt),
        .o_V_CNT   (w_v_cnt),
        .o_VISIBLE (w_visible)
    );

    // One fetch per 4-pixel group, at the first column of the group.
    assign w_read_slot = w_visible & (w_h_cnt[SCALE_LOG2-1:0] == '0);
    assign w_slot      = w_read_slot ? SLOT_READ : SLOT_WRITE;
    assign w_fb_addr   = fb_addr(FB_ADDR_W'(w_h_cnt), FB_ADDR_W'(w_v_cnt));
    // Out-of-range writes are acknowledged but dropped.
    assign w_addr_ok   = i_WR_ADDR < FB_ADDR_W'(FB_SIZE);

    // RAM port mux; the scan-out read always wins its slot.
    always_comb begin
        w_mem.we   = 1'b0;
        w_mem.addr = i_WR_ADDR;
        w_mem.data = i_WR_DATA;
        o_WR_ACK   = 1'b0;
        case (w_slot)
            SLOT_READ: w_mem.addr = w_fb_addr;
            default: begin
                o_WR_ACK = i_WR_REQ & ~i_RESET;
                w_mem.we = i_WR_REQ & ~i_RESET & w_addr_ok;
            end
        endcase
    end

    assign o_MEM_ADDR  = w_mem.addr;
    assign o_MEM_WE    = w_mem.we;
    assign o_MEM_WDATA = w_mem.data;

    // Two-stage display pipeline: address cycle, RAM data cycle, then display.
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            r_vis_d1 <= 1'b0;
            r_rd_d1  <= 1'b0;
            r_de     <= 1'b0;
            r_pix    <= '0;
            r_rgb    <= '0;
        end else begin
            r_vis_d1 <= w_visible;
            r_rd_d1  <= w_read_slot;
            r_de     <= r_vis_d1;
            if (r_rd_d1) begin
                r_pix <= i_MEM_RDATA;
            end
            // Fresh RAM data bypasses the pixel register so it shows without extra delay.
            if (!r_vis_d1) begin
                r_rgb <= '0;
            end else if (r_rd_d1) begin
                r_rgb <= i_MEM_RDATA;
            end else begin
                r_rgb <= r_pix;
            end
        end
    end

    assign o_RGB = r_rgb;
    assign o_DE  = r_de;

    assign o_FRAME_START = ~i_RESET & (w_h_cnt == '0) & (w_v_cnt == '0);

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter on a reduced raster (64x48 in 80x53).
module tb_vga_fb_arbiter;

    localparam int H_ACT = 64;
    localparam int H_TOT = 80;
    localparam int V_ACT = 48;
    localparam int V_TOT = 53;
    localparam int FRAME = H_TOT * V_TOT;
    localparam int FB_W  = 160;
    localparam int FB_N  = 19200;

    typedef struct packed {
        logic       de;
        logic [7:0] rgb;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_req = 1'b0;
    logic [14:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_ack;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic [7:0]  rgb;
    logic        de;
    logic        fs;

    logic [7:0] ram     [0:32767];
    logic [7:0] exp_mem [0:32767];

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    vga_fb_arbiter #(
        .H_ACTIVE (H_ACT),
        .H_TOTAL  (H_TOT),
        .V_ACTIVE (V_ACT),
        .V_TOTAL  (V_TOT)
    ) dut (
        .i_CLK         (clk),
        .i_RESET       (rst),
        .i_WR_REQ      (wr_req),
        .i_WR_ADDR     (wr_addr),
        .i_WR_DATA     (wr_data),
        .o_WR_ACK      (wr_ack),
        .o_MEM_ADDR    (mem_addr),
        .o_MEM_WE      (mem_we),
        .o_MEM_WDATA   (mem_wdata),
        .i_MEM_RDATA   (mem_rdata),
        .o_RGB         (rgb),
        .o_DE          (de),
        .o_FRAME_START (fs)
    );

    always #5 clk = ~clk;

    // Synchronous read-first RAM.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // Cycles since reset release; scan position = cyc mod raster.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic logic [7:0] pat(input int a);
        logic [7:0] lo;
        lo = 8'(a);
        if (a == 0) return 8'hE0;
        if (a == 1) return 8'h1C;
        return lo ^ 8'h5A;
    endfunction

    // Expected pixel pushed at scan time, compared when the DUT shows it 2 cycles later.
    task automatic run_scoreboard();
        pix_t q[$];
        pix_t e;
        logic [7:0] m_pix;
        int h;
        int v;
        m_pix = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                m_pix = 8'h00;
            end else begin
                h = cyc % H_TOT;
                v = (cyc / H_TOT) % V_TOT;
                e.de = (h < H_ACT) && (v < V_ACT);
                if (e.de && (h % 4 == 0)) m_pix = exp_mem[(v / 4) * FB_W + h / 4];
                e.rgb = e.de ? m_pix : 8'h00;
                q.push_back(e);
                if (q.size() > 2) begin
                    e = q.pop_front();
                    n_vec++;
                    if (de !== e.de || rgb !== e.rgb) begin
                        n_err++;
                        $display("FAIL scoreboard (now h=%0d v=%0d): got de=%b rgb=%h, want de=%b rgb=%h",
                                 h, v, de, rgb, e.de, e.rgb);
                    end
                end
            end
        end
    endtask

    // Advance to the negedge of scan position (h,v); bounded by two frames.
    task automatic wait_pos(input int h, input int v);
        int tgt;
        tgt = v * H_TOT + h;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (cyc % FRAME == tgt) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_req = 1'b1; wr_addr = 15'd5; wr_data = 8'hAA;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (wr_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b want 0", wr_ack); end
        n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", mem_we); end
        n_vec++; if (fs !== 1'b0) begin n_err++; $display("FAIL reset_fs: got %b want 0", fs); end
        n_vec++; if (de !== 1'b0 || rgb !== 8'h00) begin n_err++; $display("FAIL reset_pix: got de=%b rgb=%h want 0/00", de, rgb); end
        wr_req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_vec++; if (fs !== 1'b1) begin n_err++; $display("FAIL release_fs: got %b want 1", fs); end
        @(negedge clk);
        n_vec++; if (fs !== 1'b0) begin n_err++; $display("FAIL release_fs_next: got %b want 0", fs); end
    endtask

    task automatic test_frame();
        int n_fs;
        int n_de;
        int at;
        n_fs = 0; n_de = 0; at = -1;
        wait_pos(0, 0);
        n_vec++; if (fs !== 1'b1) begin n_err++; $display("FAIL frame_fs_origin: got %b want 1", fs); end
        for (int i = 1; i <= FRAME; i++) begin
            @(negedge clk);
            if (fs === 1'b1) begin n_fs++; if (at < 0) at = i; end
            if (de === 1'b1) n_de++;
        end
        n_vec++; if (n_fs !== 1) begin n_err++; $display("FAIL frame_fs_count: got %0d want 1", n_fs); end
        n_vec++; if (at !== FRAME) begin n_err++; $display("FAIL frame_fs_period: got %0d want %0d", at, FRAME); end
        n_vec++; if (n_de !== H_ACT * V_ACT) begin n_err++; $display("FAIL frame_de_count: got %0d want %0d", n_de, H_ACT * V_ACT); end
    endtask

    task automatic test_pixels();
        logic [7:0] want;
        wait_pos(0, 0);
        n_vec++; if (de !== 1'b0 || rgb !== 8'h00) begin n_err++; $display("FAIL line0_h0: got de=%b rgb=%h want 0/00", de, rgb); end
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            want = (k < 2) ? 8'h00 : (k < 6) ? 8'hE0 : 8'h1C;
            n_vec++;
            if (rgb !== want || de !== (k >= 2)) begin
                n_err++; $display("FAIL line0_h%0d: got de=%b rgb=%h want rgb=%h", k, de, rgb, want);
            end
        end
    endtask

    task automatic test_collision();
        wait_pos(3, 0);
        @(posedge clk); #1 wr_req = 1'b1; wr_addr = 15'd161; wr_data = 8'h3F;
        @(negedge clk);
        n_vec++; if (wr_ack !== 1'b0) begin n_err++; $display("FAIL collide_h4_ack: got %b want 0", wr_ack); end
        n_vec++; if (mem_we !== 1'b0 || mem_addr !== 15'd1) begin n_err++; $display("FAIL collide_h4_read: got we=%b addr=%0d want 0/1", mem_we, mem_addr); end
        @(negedge clk);
        n_vec++; if (wr_ack !== 1'b1) begin n_err++; $display("FAIL collide_h5_ack: got %b want 1", wr_ack); end
        n_vec++; if (mem_we !== 1'b1 || mem_addr !== 15'd161 || mem_wdata !== 8'h3F) begin
            n_err++; $display("FAIL collide_h5_write: got we=%b addr=%0d data=%h want 1/161/3f", mem_we, mem_addr, mem_wdata);
        end
        if (wr_ack === 1'b1) exp_mem[161] = 8'h3F;
        @(posedge clk); #1 wr_req = 1'b0;
        @(negedge clk);
        n_vec++; if (ram[161] !== 8'h3F) begin n_err++; $display("FAIL collide_ram: got %h want 3f", ram[161]); end
        wait_pos(0, 0);
        for (int v = 4; v <= 7; v++) begin
            wait_pos(5, v);
            for (int h = 6; h <= 9; h++) begin
                @(negedge clk);
                n_vec++;
                if (rgb !== 8'h3F || de !== 1'b1) begin
                    n_err++; $display("FAIL collide_show v=%0d h=%0d: got de=%b rgb=%h want 1/3f", v, h, de, rgb);
                end
            end
        end
    endtask

    task automatic test_blank_writes();
        int n_ack;
        n_ack = 0;
        wait_pos(H_TOT - 1, 49);
        @(posedge clk); #1 wr_req = 1'b1; wr_addr = 15'd320; wr_data = 8'd3;
        for (int i = 0; i < H_TOT; i++) begin
            @(negedge clk);
            n_vec++;
            if (wr_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== wr_addr) begin
                n_err++; $display("FAIL blank_write i=%0d: got ack=%b we=%b addr=%0d want 1/1/%0d", i, wr_ack, mem_we, mem_addr, wr_addr);
            end
            if (wr_ack === 1'b1) begin n_ack++; exp_mem[wr_addr] = wr_data; end
            @(posedge clk); #1;
            if (i < H_TOT - 1) begin
                wr_addr = 15'(320 + (i + 1) % 16 + FB_W * ((i + 1) / 16));
                wr_data = 8'((i + 1) * 7 + 3);
            end else begin
                wr_req = 1'b0;
            end
        end
        n_vec++; if (n_ack !== H_TOT) begin n_err++; $display("FAIL blank_ack_count: got %0d want %0d", n_ack, H_TOT); end
    endtask

    task automatic test_active_throughput();
        int  n_ack;
        logic want;
        n_ack = 0;
        wait_pos(H_TOT - 1, 9);
        @(posedge clk); #1 wr_req = 1'b1; wr_addr = 15'd16000; wr_data = 8'h00;
        for (int i = 0; i < H_TOT; i++) begin
            @(negedge clk);
            want = !((i < H_ACT) && (i % 4 == 0));
            n_vec++;
            if (wr_ack !== want) begin n_err++; $display("FAIL active_ack h=%0d: got %b want %b", i, wr_ack, want); end
            if (wr_ack === 1'b1) begin
                n_ack++;
                exp_mem[wr_addr] = wr_data;
                @(posedge clk); #1 wr_addr = wr_addr + 15'd1; wr_data = wr_data + 8'd1;
            end
        end
        @(posedge clk); #1 wr_req = 1'b0;
        n_vec++; if (n_ack !== H_TOT - H_ACT / 4) begin n_err++; $display("FAIL active_ack_count: got %0d want %0d", n_ack, H_TOT - H_ACT / 4); end
    endtask

    task automatic test_oob();
        wait_pos(9, 51);
        @(posedge clk); #1 wr_req = 1'b1; wr_addr = 15'(FB_N); wr_data = 8'h77;
        @(negedge clk);
        n_vec++; if (wr_ack !== 1'b1 || mem_we !== 1'b0) begin n_err++; $display("FAIL oob_19200: got ack=%b we=%b want 1/0", wr_ack, mem_we); end
        @(posedge clk); #1 wr_addr = 15'(FB_N - 1); wr_data = 8'h66;
        @(negedge clk);
        n_vec++; if (wr_ack !== 1'b1 || mem_we !== 1'b1) begin n_err++; $display("FAIL oob_19199: got ack=%b we=%b want 1/1", wr_ack, mem_we); end
        if (wr_ack === 1'b1) exp_mem[FB_N - 1] = 8'h66;
        @(posedge clk); #1 wr_req = 1'b0;
        @(negedge clk);
        n_vec++; if (ram[FB_N] !== pat(FB_N)) begin n_err++; $display("FAIL oob_ram_19200: got %h want %h", ram[FB_N], pat(FB_N)); end
        n_vec++; if (ram[FB_N - 1] !== 8'h66) begin n_err++; $display("FAIL oob_ram_19199: got %h want 66", ram[FB_N - 1]); end
    endtask

    task automatic test_reset_mid();
        wait_pos(29, 20);
        n_vec++; if (de !== 1'b1) begin n_err++; $display("FAIL midreset_pre_de: got %b want 1", de); end
        @(posedge clk); #1 wr_req = 1'b1; wr_addr = 15'd7; wr_data = 8'h11; rst = 1'b1;
        #1;
        n_vec++; if (rgb !== 8'h00 || de !== 1'b0) begin n_err++; $display("FAIL midreset_pix: got de=%b rgb=%h want 0/00", de, rgb); end
        n_vec++; if (wr_ack !== 1'b0 || mem_we !== 1'b0 || fs !== 1'b0) begin
            n_err++; $display("FAIL midreset_ctl: got ack=%b we=%b fs=%b want 0/0/0", wr_ack, mem_we, fs);
        end
        repeat (2) @(posedge clk);
        #1 wr_req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_vec++; if (fs !== 1'b1) begin n_err++; $display("FAIL midreset_fs: got %b want 1", fs); end
        n_vec++; if (ram[7] !== pat(7)) begin n_err++; $display("FAIL midreset_no_write: got %h want %h", ram[7], pat(7)); end
    endtask

    initial begin
        for (int a = 0; a < 32768; a++) begin
            ram[a]     = pat(a);
            exp_mem[a] = pat(a);
        end
        fork
            run_scoreboard();
        join_none
        test_reset();
        test_frame();
        test_pixels();
        test_collision();
        test_blank_writes();
        test_active_throughput();
        test_oob();
        test_reset_mid();
        repeat (FRAME + 8) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_TOTAL, default 800, pixel clocks per line.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameter V_TOTAL, default 525, lines per frame.
REQ-005 SHALL have port i_CLK  in  1  25 MHz pixel clock; the only clock.
REQ-006 SHALL have port i_RESET  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port i_WR_REQ  in  1  game-logic write request.
REQ-008 SHALL have port i_WR_ADDR  in  15  frame-buffer write address.
REQ-009 SHALL have port i_WR_DATA  in  8  RGB332 write data.
REQ-010 SHALL have port o_WR_ACK  out  1  write accepted this cycle.
REQ-011 SHALL have port o_MEM_ADDR  out  15  single-port RAM address.
REQ-012 SHALL have port o_MEM_WE  out  1  RAM write enable.
REQ-013 SHALL have port o_MEM_WDATA  out  8  RAM write data.
REQ-014 SHALL have port i_MEM_RDATA  in  8  RAM read data, valid 1 cycle after address.
REQ-015 SHALL have port o_RGB  out  8  pixel byte for VGA_CONTROLLER i_RGB.
REQ-016 SHALL have port o_DE  out  1  o_RGB carries a visible pixel.
REQ-017 SHALL have port o_FRAME_START  out  1  one-cycle pulse at scan position (0,0).

Function
REQ-018 SHALL keep h_cnt 0..H_TOTAL-1, incrementing every cycle and wrapping to 0; v_cnt 0..V_TOTAL-1 SHALL increment on h wrap and wrap to 0 after V_TOTAL-1.
REQ-019 SHALL map the 160x120 frame buffer onto 640x480 with 4x4 replication: fb_addr = (v_cnt>>2)*160 + (h_cnt>>2), computed as ((v>>2)<<7)+((v>>2)<<5)+(h>>2), with no multiplier.
REQ-020 SHALL define read slot = (h_cnt<H_ACTIVE) & (v_cnt<V_ACTIVE) & (h_cnt[1:0]==0); in a read slot o_MEM_ADDR=fb_addr, o_MEM_WE=0.
REQ-021 SHALL latch i_MEM_RDATA into the pixel register on the cycle after a read slot; o_RGB SHALL equal that register while o_DE=1 and 0 otherwise.
REQ-022 SHALL assert o_DE exactly 2 cycles after the counters enter the visible region; total display latency SHALL be 2 cycles, so column group c is shown at h_cnt 4c+2..4c+5.
REQ-023 SHALL treat every non-read-slot cycle as a write slot; o_WR_ACK = i_WR_REQ & ~read_slot, combinational, with o_MEM_ADDR=i_WR_ADDR and o_MEM_WDATA=i_WR_DATA.
REQ-024 Requester SHALL hold i_WR_ADDR/i_WR_DATA stable while i_WR_REQ=1 and o_WR_ACK=0; a request held high after ack SHALL be treated as a new write, giving a throughput of 1/cycle in blanking and 3/4 in active region.
REQ-025 SHALL, on a write with i_WR_ADDR>=19200, still assert o_WR_ACK with o_MEM_WE=0, so that no RAM write occurs.
REQ-026 SHALL give read slots absolute priority; a write colliding with a read slot SHALL get o_WR_ACK=0 and be accepted on the next cycle.
REQ-027 SHALL drive o_FRAME_START=1 only on the cycle where h_cnt=0 and v_cnt=0, and never while i_RESET=1.

Reset
REQ-028 SHALL clear h_cnt, v_cnt, the pixel register, o_RGB and the o_DE pipeline to 0 asynchronously on i_RESET=1.
REQ-029 SHALL hold o_WR_ACK=0, o_MEM_WE=0 and o_FRAME_START=0 while i_RESET=1.
REQ-030 SHALL, on reset deassertion mid-frame, restart scanning at (0,0) and raise o_FRAME_START on the first cycle.
REQ-031 SHALL NOT retain an unacked write across reset.

Structure
REQ-032 SHALL place the timing defaults, FB_WIDTH=160, FB_HEIGHT=120, FB_SIZE=19200, FB_ADDR_W=15 and SCALE_LOG2=2 in shared package vga_fb_pkg.
REQ-033 SHALL implement the h/v counters as sub-module vga_scan_counter, which outputs h_cnt, v_cnt and the visible flag.

Verification
REQ-034 SHALL verify: reset release, then run one frame -> o_FRAME_START pulses once every 420000 cycles; o_DE is high for 307200 cycles per frame.
REQ-035 SHALL verify: RAM model with addr 0=8'hE0 and addr 1=8'h1C -> at line 0, o_RGB=E0 for h_cnt 2..5 and 1C for h_cnt 6..9.
REQ-036 SHALL verify: i_WR_REQ held with addr 161, data 8'h3F, issued at h_cnt=4, v_cnt=0 -> ack at h_cnt=5, not 4; the RAM gets 3F; in the next frame o_RGB=3F at v=4..7, h=6..9.
REQ-037 SHALL verify: continuous writes during v_cnt=490 -> o_WR_ACK=1 on every cycle of that line; zero read slots occur.
REQ-038 SHALL verify: write to addr 19200 -> o_WR_ACK=1, o_MEM_WE=0, RAM unchanged.
REQ-039 SHALL verify: i_RESET pulsed at h_cnt=300, v_cnt=200 -> o_RGB=0 and o_DE=0 immediately; o_FRAME_START on the first cycle after release.
